// File: rtl/register_file_sb_if.sv
// Decode/writeback side of the RV32I register file: read ports, write port,
// scoreboard set/flush and the busy count.
interface register_file_sb_if #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [XLEN-1:0]              wr_data;
    logic [NUM_RD_PORTS*AW-1:0]   rd_addr;
    logic [NUM_RD_PORTS*XLEN-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]      rd_busy;
    logic                         sb_set_en;
    logic [AW-1:0]                sb_set_addr;
    logic                         sb_flush;
    logic [CW-1:0]                busy_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, sb_flush,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, sb_flush,
        output rd_data, rd_busy, busy_count
    );
endinterface

// File: rtl/register_file_sb.sv
// Integer register file with per-register busy scoreboard, write-to-read
// bypass and an optional registered read stage.

// One read port: address qualification, bypass mux and optional output stage.
module register_file_sb_rdport #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AW-1:0]                      addr,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      regs,
    input  logic [NUM_REGS-1:0]                busy,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [XLEN-1:0]                    wr_data,
    output logic [XLEN-1:0]                    rd_data,
    output logic                               rd_busy
);
    localparam logic [AW:0] NREG = (AW+1)'(NUM_REGS);

    logic            in_rng;
    logic            hit;
    logic [XLEN-1:0] val;
    logic            bsy;

    assign in_rng = (addr != '0) && ({1'b0, addr} < NREG);
    assign hit    = (BYPASS != 0) && wr_en && (wr_addr == addr);

    // The retiring value is forwarded, so its pending producer no longer stalls.
    always_comb begin
        val = '0;
        bsy = 1'b0;
        if (in_rng) begin
            val = hit ? wr_data : regs[addr];
            bsy = busy[addr] && !hit;
        end
    end

    if (READ_REG != 0) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data <= '0;
                rd_busy <= 1'b0;
            end else begin
                rd_data <= val;
                rd_busy <= bsy;
            end
        end
    end else begin : g_comb
        wire unused_clk_rst = &{1'b0, clk, rst};
        assign rd_data = val;
        assign rd_busy = bsy;
    end
endmodule

module register_file_sb #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1,
    parameter int READ_REG     = 0
) (
    input  logic           clk,
    input  logic           rst,
    register_file_sb_if.slave bus
);
    localparam int          AW   = $clog2(NUM_REGS);
    localparam int          CW   = $clog2(NUM_REGS + 1);
    localparam logic [AW:0] NREG = (AW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][XLEN-1:0]     regs;
    logic [NUM_REGS-1:0]               busy;
    logic [NUM_REGS-1:0]               busy_nxt;
    logic [CW-1:0]                     cnt_nxt;
    logic [CW-1:0]                     cnt_q;
    logic                              wr_ok;
    logic                              set_ok;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_q;
    logic [NUM_RD_PORTS-1:0]           bsy_q;

    // x0 and out-of-range addresses never hold state.
    assign wr_ok  = bus.wr_en && (bus.wr_addr != '0) && ({1'b0, bus.wr_addr} < NREG);
    assign set_ok = bus.sb_set_en && (bus.sb_set_addr != '0) &&
                    ({1'b0, bus.sb_set_addr} < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        regs <= '0;
        else if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
    end

    // Flush beats set beats clear; a new producer supersedes the retiring one.
    always_comb begin
        busy_nxt = busy;
        if (bus.sb_flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_ok)  busy_nxt[bus.wr_addr]     = 1'b0;
            if (set_ok) busy_nxt[bus.sb_set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end

    // Counting next-state keeps busy_count aligned with the busy bits it reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        register_file_sb_rdport #(
            .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .READ_REG(READ_REG), .AW(AW)
        ) u_rd (
            .clk     (clk),
            .rst     (rst),
            .addr    (bus.rd_addr[p*AW +: AW]),
            .regs    (regs),
            .busy    (busy),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (rd_q[p]),
            .rd_busy (bsy_q[p])
        );
    end

    assign bus.rd_data    = rd_q;
    assign bus.rd_busy    = bsy_q;
    assign bus.busy_count = cnt_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed vector table and random run against a
// reference model on a combinational instance, plus registered-read sequences.
module tb_register_file_sb;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    register_file_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2)) ba();
    register_file_sb_if #(.XLEN(32), .NUM_REGS(16), .NUM_RD_PORTS(2)) bb();

    register_file_sb #(.NUM_REGS(32), .BYPASS(1), .READ_REG(0))
        dut_a (.clk(clk), .rst(rst_a), .bus(ba.slave));
    register_file_sb #(.NUM_REGS(16), .BYPASS(1), .READ_REG(1))
        dut_b (.clk(clk), .rst(rst_b), .bus(bb.slave));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        se;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] ed0, ed1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t tbl[20];

    // Reference state for instance A.
    logic [31:0] mreg [32];
    logic        mbusy[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic se,
                                logic [4:0] sa, logic fl, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] ed0, logic [31:0] ed1, logic [1:0] eb,
                                logic [5:0] ec);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.se = se; v.sa = sa; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic se, input logic [4:0] sa, input logic fl,
                           input logic [4:0] ra0, input logic [4:0] ra1);
        ba.wr_en = we; ba.wr_addr = wa; ba.wr_data = wd;
        ba.sb_set_en = se; ba.sb_set_addr = sa; ba.sb_flush = fl;
        ba.rd_addr = {ra1, ra0};
    endtask

    function automatic logic [31:0] m_rd(logic [4:0] a, logic we, logic [4:0] wa,
                                         logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic m_busy(logic [4:0] a, logic we, logic [4:0] wa);
        return (a != 0) && mbusy[a] && !(we && wa == a);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) if (mbusy[r]) c++;
        return c;
    endfunction

    task automatic m_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic se, input logic [4:0] sa, input logic fl);
        if (we && wa != 0) mreg[wa] = wd;
        for (int r = 1; r < 32; r++) begin
            if (fl)                 mbusy[r] = 1'b0;
            else if (se && sa == r) mbusy[r] = 1'b1;
            else if (we && wa == r) mbusy[r] = 1'b0;
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        bb.wr_en = 0; bb.wr_addr = 0; bb.wr_data = 0; bb.sb_set_en = 0;
        bb.sb_set_addr = 0; bb.sb_flush = 0; bb.rd_addr = 0;

        //                we wa  wd            se sa fl ra0 ra1 ed0           ed1           eb     ec
        tbl[0]  = mk(0, 0,  0,            0, 0, 0, 0,  31, 0,            0,            2'b00, 0);
        tbl[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        tbl[2]  = mk(0, 0,  0,            0, 0, 0, 5,  6,  32'hDEADBEEF, 0,            2'b00, 0);
        tbl[3]  = mk(1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  0,  0,            0,            2'b00, 0);
        tbl[4]  = mk(0, 0,  0,            0, 0, 0, 0,  0,  0,            0,            2'b00, 0);
        tbl[5]  = mk(0, 0,  0,            1, 7, 0, 7,  7,  0,            0,            2'b00, 0);
        tbl[6]  = mk(0, 0,  0,            0, 0, 0, 7,  1,  0,            0,            2'b01, 1);
        tbl[7]  = mk(0, 0,  0,            0, 0, 0, 7,  7,  0,            0,            2'b11, 1);
        tbl[8]  = mk(1, 7,  32'h1234,     0, 0, 0, 7,  7,  32'h1234,     32'h1234,     2'b00, 1);
        tbl[9]  = mk(0, 0,  0,            0, 0, 0, 7,  7,  32'h1234,     32'h1234,     2'b00, 0);
        tbl[10] = mk(1, 3,  32'hAA,       1, 3, 0, 3,  7,  32'hAA,       32'h1234,     2'b00, 0);
        tbl[11] = mk(0, 0,  0,            0, 0, 0, 3,  3,  32'hAA,       32'hAA,       2'b11, 1);
        tbl[12] = mk(1, 3,  32'hBB,       1, 1, 0, 1,  3,  0,            32'hBB,       2'b00, 1);
        tbl[13] = mk(0, 0,  0,            1, 2, 0, 1,  3,  0,            32'hBB,       2'b01, 1);
        tbl[14] = mk(0, 0,  0,            1, 4, 0, 2,  4,  0,            0,            2'b01, 2);
        tbl[15] = mk(0, 0,  0,            0, 0, 0, 4,  9,  0,            0,            2'b01, 3);
        tbl[16] = mk(0, 0,  0,            1, 9, 1, 9,  1,  0,            0,            2'b10, 3);
        tbl[17] = mk(0, 0,  0,            0, 0, 0, 9,  1,  0,            0,            2'b00, 0);
        tbl[18] = mk(1, 9,  32'h99,       0, 0, 0, 9,  9,  32'h99,       32'h99,       2'b00, 0);
        tbl[19] = mk(0, 0,  0,            0, 0, 0, 9,  10, 32'h99,       0,            2'b00, 0);

        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state: every register on every port reads zero and idle.
        for (int a = 0; a < 32; a++) begin
            ba.rd_addr = {5'(31 - a), 5'(a)};
            #0.1;
            chk($sformatf("rst_p0_x%0d", a), ba.rd_data[31:0], 32'h0);
            chk($sformatf("rst_p1_x%0d", 31 - a), ba.rd_data[63:32], 32'h0);
            chk($sformatf("rst_busy_x%0d", a), {30'h0, ba.rd_busy}, 32'h0);
        end
        chk("rst_busy_count", {26'h0, ba.busy_count}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_a(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].se, tbl[i].sa, tbl[i].fl,
                    tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("vec%0d_d0", i), ba.rd_data[31:0], tbl[i].ed0);
            chk($sformatf("vec%0d_d1", i), ba.rd_data[63:32], tbl[i].ed1);
            chk($sformatf("vec%0d_busy", i), {30'h0, ba.rd_busy}, {30'h0, tbl[i].eb});
            chk($sformatf("vec%0d_cnt", i), {26'h0, ba.busy_count}, {26'h0, tbl[i].ec});
        end

        // Random run from a fresh reset against the reference model.
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        rst_a = 1'b1;
        for (int r = 0; r < 32; r++) begin mreg[r] = 0; mbusy[r] = 0; end
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic we, se, fl;
            logic [4:0] wa, sa, ra0, ra1;
            logic [31:0] wd;
            logic [4:0] amask;
            @(negedge clk);
            amask = (i % 2 == 0) ? 5'd7 : 5'd31;
            we  = 1'($urandom);
            wa  = 5'($urandom) & amask;
            wd  = $urandom;
            se  = ($urandom_range(0, 2) == 0);
            sa  = 5'($urandom) & amask;
            fl  = ($urandom_range(0, 19) == 0);
            ra0 = 5'($urandom) & amask;
            ra1 = 5'($urandom) & amask;
            drive_a(we, wa, wd, se, sa, fl, ra0, ra1);
            #1;
            chk($sformatf("rnd%0d_d0", i), ba.rd_data[31:0], m_rd(ra0, we, wa, wd));
            chk($sformatf("rnd%0d_d1", i), ba.rd_data[63:32], m_rd(ra1, we, wa, wd));
            chk($sformatf("rnd%0d_busy", i), {30'h0, ba.rd_busy},
                {30'h0, m_busy(ra1, we, wa), m_busy(ra0, we, wa)});
            chk($sformatf("rnd%0d_cnt", i), {26'h0, ba.busy_count}, 32'(m_count()));
            @(posedge clk);
            m_step(we, wa, wd, se, sa, fl);
        end

        // Registered read: data appears exactly one edge after the address.
        @(negedge clk);
        bb.wr_en = 1; bb.wr_addr = 4'd15; bb.wr_data = 32'h55;
        @(negedge clk);
        bb.wr_en = 0; bb.rd_addr = {4'd15, 4'd15};
        #1 chk("b_before_capture", bb.rd_data[31:0], 32'h0);
        @(posedge clk);
        #1;
        chk("b_lat1_p0", bb.rd_data[31:0], 32'h55);
        chk("b_lat1_p1", bb.rd_data[63:32], 32'h55);

        @(negedge clk);
        bb.sb_set_en = 1; bb.sb_set_addr = 4'd15;
        @(negedge clk);
        bb.sb_set_en = 0;
        chk("b_busy_captured_pre", {30'h0, bb.rd_busy}, 32'h0);
        chk("b_busy_count", {27'h0, bb.busy_count}, 32'h1);
        @(posedge clk);
        #1 chk("b_busy_registered", {30'h0, bb.rd_busy}, 32'h3);

        // Asynchronous reset between address and capture.
        @(negedge clk);
        #1 rst_b = 1'b1;
        #1;
        chk("b_rst_rd_data", bb.rd_data[31:0], 32'h0);
        chk("b_rst_rd_busy", {30'h0, bb.rd_busy}, 32'h0);
        chk("b_rst_busy_count", {27'h0, bb.busy_count}, 32'h0);
        #1 rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("b_x15_cleared_p0", bb.rd_data[31:0], 32'h0);
        chk("b_x15_cleared_p1", bb.rd_data[63:32], 32'h0);

        // A write presented while reset is held is discarded.
        @(negedge clk);
        bb.wr_en = 1; bb.wr_addr = 4'd5; bb.wr_data = 32'h77; rst_b = 1'b1;
        @(negedge clk);
        bb.wr_en = 0; rst_b = 1'b0; bb.rd_addr = {4'd5, 4'd5};
        @(posedge clk);
        #1 chk("b_write_in_rst", bb.rd_data[31:0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised integer register file for the RV32I pipeline with:
  - NUM_RD_PORTS read ports.
  - One write port.
  - Optional write-to-read bypass.
  - Optional registered read stage.
- Includes a per-register scoreboard (busy bits) so decode can detect RAW hazards against in-flight producers.
- Sits between decode (read/issue) and writeback (write/clear).
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers (2..64); AW = $clog2(NUM_REGS).
- NUM_RD_PORTS, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to reads of the same address.
- READ_REG, 0, 0 = combinational read (latency 0); 1 = registered read (latency 1).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  writeback valid.
- wr_addr  input  AW  writeback destination register.
- wr_data  input  XLEN  writeback value.
- rd_addr  input  NUM_RD_PORTS*AW  packed read addresses; port p = bits [p*AW +: AW].
- rd_data  output  NUM_RD_PORTS*XLEN  packed read data; port p = bits [p*XLEN +: XLEN].
- rd_busy  output  NUM_RD_PORTS  port p's register has a pending producer.
- sb_set_en  input  1  issue of an instruction that will write sb_set_addr.
- sb_set_addr  input  AW  destination register of the issued instruction.
- sb_flush  input  1  pipeline flush; clears all busy bits.
- busy_count  output  $clog2(NUM_REGS+1)  number of busy registers.

Behaviour:
- Reset (rst=1, asynchronous):
  - All registers = 0; all busy bits = 0; busy_count = 0.
  - If READ_REG=1, registered rd_data = 0 and registered rd_busy = 0.
  - rst asserted mid-operation discards any write or set in that cycle.
- Write, on rising clk:
  - If wr_en=1 and wr_addr != 0 and wr_addr < NUM_REGS: reg[wr_addr] <= wr_data.
  - Writes to address 0 or to an out-of-range address are ignored.
- Read value per port p, with address a = rd_addr[p]:
  - a == 0 or a >= NUM_REGS -> 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr == a -> wr_data.
  - Else -> reg[a].
- READ_REG=0: rd_data and rd_busy are combinational from the current inputs and state.
- READ_REG=1: the same values are captured every rising clk and presented the cycle after the address; there is no enable, so reads are continuous.
- Busy bits, next-state priority per register r (highest first):
  1. sb_flush=1 -> busy[r] <= 0 for all r; a same-cycle set is discarded.
  2. sb_set_en=1 and sb_set_addr == r, r != 0 -> busy[r] <= 1. Set wins over a same-cycle clear, because the new producer supersedes the retiring one.
  3. wr_en=1 and wr_addr == r -> busy[r] <= 0.
  4. Otherwise hold.
  - busy[0] is constant 0.
- rd_busy[p] = busy[a] AND NOT (BYPASS=1 AND wr_en=1 AND wr_addr == a), and 0 when a == 0 or a is out of range.
  - The retiring value is forwarded, so no stall is signalled for it.
  - With BYPASS=0, rd_busy stays 1 for the writeback cycle; the value is readable the next cycle.
- busy_count is a registered population count of the busy bits. It reflects state after the last edge, not combinational next-state.
- Multiple read ports may address the same register; each port returns identical data.
- Write and set to the same register in the same cycle:
  - The data is written.
  - The busy bit ends at 1.
- Write while busy is clear (e.g. a post-flush stale writeback): the data is still written and the busy bit stays 0.

Test Plan:
- Reset, then read all registers on every port -> all 0, rd_busy = 0, busy_count = 0. Write x5 = 0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF.
- Write x0 = 0xFFFFFFFF, then read x0 on both ports -> 0. Also set busy on x0 -> rd_busy = 0 and busy_count = 0.
- BYPASS=1, READ_REG=0:
  - Cycle 0: sb_set x7.
  - Cycle 2: read x7 with no write -> rd_busy = 1.
  - Cycle 3: write x7 = 0x1234 while reading x7 -> same cycle rd_data = 0x1234, rd_busy = 0.
  - Next cycle: busy_count = 0.
- Same cycle: sb_set x3 and wr x3 = 0xAA -> next cycle reg x3 = 0xAA, busy[x3] = 1, busy_count = 1.
- sb_set x1, x2 and x4 on successive cycles, so busy_count = 3; then sb_flush together with sb_set x9 -> busy_count = 0 and rd_busy = 0 on x9.
- READ_REG=1, NUM_REGS=16, AW=4: write x15 = 0x55, then present address 15 -> rd_data = 0x55 exactly one cycle later. Assert rst between address and capture -> rd_data = 0 and x15 = 0 afterward.
